// File: rtl/crc32_8023_gen.sv
// Byte-serial IEEE 802.3 CRC-32 engine: folds one reflected data byte per clock,
// then shifts out the four inverted, bit-reflected FCS bytes in wire order.
module crc32_8023_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  d,
  input  logic        load_init,
  input  logic        calc,
  input  logic        d_valid,
  output logic [31:0] crc_reg,
  output logic [7:0]  crc
);

  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] INIT = 32'hFFFFFFFF;

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Eight MSB-first LFSR steps; the unrolled loop collapses into one level of
  // XOR equations per register bit, so the update closes in a single cycle.
  function automatic logic [31:0] next_crc(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    logic        fb;
    c = c_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[31] ^ b[i];
      c  = {c[30:0], 1'b0};
      if (fb) c = c ^ POLY;
    end
    return c;
  endfunction

  logic [31:0] nc;

  always_comb begin
    nc = next_crc(crc_reg, rev8(d));
  end

  always_ff @(posedge clk) begin
    if (reset || load_init) begin
      crc_reg <= INIT;
      crc     <= 8'hFF;
    end else if (d_valid && calc) begin
      crc_reg <= nc;
      crc     <= ~rev8(nc[31:24]);
    end else if (d_valid) begin
      // FCS byte 0 already left with the last data byte, so present the next one.
      crc_reg <= {crc_reg[23:0], 8'hFF};
      crc     <= ~rev8(crc_reg[23:16]);
    end
  end

endmodule

// File: tb/tb_crc32_8023_gen.sv
// Scoreboard bench for crc32_8023_gen: stimulus pushes expected register/byte
// values, a negedge monitor pops and compares them against the DUT outputs.
module tb_crc32_8023_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  d;
  logic        load_init;
  logic        calc;
  logic        d_valid;
  logic [31:0] crc_reg;
  logic [7:0]  crc;

  always #5 clk = ~clk;

  crc32_8023_gen dut (
    .clk      (clk),
    .reset    (reset),
    .d        (d),
    .load_init(load_init),
    .calc     (calc),
    .d_valid  (d_valid),
    .crc_reg  (crc_reg),
    .crc      (crc)
  );

  typedef struct packed {
    logic [31:0] reg_exp;
    logic [7:0]  crc_exp;
    logic        chk_reg;
    logic        chk_crc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests = 0;
  int    fails = 0;

  logic [7:0] msg [9];
  initial begin
    msg[0] = 8'h31; msg[1] = 8'h32; msg[2] = 8'h33;
    msg[3] = 8'h34; msg[4] = 8'h35; msg[5] = 8'h36;
    msg[6] = 8'h37; msg[7] = 8'h38; msg[8] = 8'h39;
  end

  // Inputs change on the falling edge; the call returns just after the rising edge.
  task automatic drive(input logic rst, input logic ld, input logic c,
                       input logic v, input logic [7:0] b);
    @(negedge clk);
    reset = rst; load_init = ld; calc = c; d_valid = v; d = b;
    @(posedge clk);
  endtask

  task automatic expect_out(input logic [31:0] r, input logic cr,
                            input logic [7:0] b, input logic cb, input string nm);
    exp_t e;
    e.reg_exp = r; e.crc_exp = b; e.chk_reg = cr; e.chk_crc = cb;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic send_msg(input bit gaps);
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, msg[i]);
      if (gaps && (i % 3 == 1)) begin
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'hA5);
      end
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      tests++;
      if ((e.chk_reg && crc_reg !== e.reg_exp) || (e.chk_crc && crc !== e.crc_exp)) begin
        fails++;
        $display("FAIL %s: crc_reg=%08h crc=%02h, required crc_reg=%08h crc=%02h (chk reg=%0d crc=%0d)",
                 nm, crc_reg, crc, e.reg_exp, e.crc_exp, e.chk_reg, e.chk_crc);
      end
    end
  end

  initial begin
    reset = 1'b1; load_init = 1'b0; calc = 1'b0; d_valid = 1'b0; d = 8'h00;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    expect_out(32'hFFFFFFFF, 1, 8'hFF, 1, "reset");
    drive(1'b0, 1'b0, 1'b1, 1'b0, 8'hAA);
    expect_out(32'hFFFFFFFF, 1, 8'hFF, 1, "hold_calc_novalid");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h55);
    expect_out(32'hFFFFFFFF, 1, 8'hFF, 1, "hold_idle");

    // Check string, FCS shift-out and over-shift
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    send_msg(1'b0);
    expect_out(32'h9B63D02C, 1, 8'h26, 1, "check_123456789");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    expect_out(32'h63D02CFF, 1, 8'h39, 1, "fcs_byte1");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    expect_out(32'hD02CFFFF, 1, 8'hF4, 1, "fcs_byte2");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    expect_out(32'h2CFFFFFF, 1, 8'hCB, 1, "fcs_byte3");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    expect_out(32'hFFFFFFFF, 1, 8'h00, 1, "overshift_4");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    expect_out(32'hFFFFFFFF, 1, 8'h00, 1, "overshift_5");

    // Single zero byte and its FCS
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    expect_out(32'hFFFFFFFF, 1, 8'hFF, 1, "load_init");
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    expect_out(32'h4E08BFB4, 1, 8'h8D, 1, "zero_byte");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    expect_out(32'h0, 0, 8'hEF, 1, "zero_fcs1");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    expect_out(32'h0, 0, 8'h02, 1, "zero_fcs2");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    expect_out(32'h0, 0, 8'hD2, 1, "zero_fcs3");

    // Residue over data plus FCS
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    send_msg(1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h26);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h39);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hF4);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hCB);
    expect_out(32'hC704DD7B, 1, 8'h00, 0, "residue_check");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h8D);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hEF);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h02);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'hD2);
    expect_out(32'hC704DD7B, 1, 8'h00, 0, "residue_zero");

    // d_valid gaps must not change the result
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    send_msg(1'b1);
    expect_out(32'h9B63D02C, 1, 8'h26, 1, "gapped_check");
    idle();
    expect_out(32'h9B63D02C, 1, 8'h26, 1, "gapped_hold");

    // load_init beats a simultaneous calc byte
    drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h31);
    expect_out(32'hFFFFFFFF, 1, 8'hFF, 1, "init_priority");
    send_msg(1'b0);
    expect_out(32'h9B63D02C, 1, 8'h26, 1, "after_init_priority");

    // Reset mid-frame, then restart without load_init
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, msg[i]);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h35);
    expect_out(32'hFFFFFFFF, 1, 8'hFF, 1, "reset_midframe");
    send_msg(1'b0);
    expect_out(32'h9B63D02C, 1, 8'h26, 1, "restart_check");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
